// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Pipeline hazard controller for a five-stage core. It decides, every
//   cycle, whether the front of the pipeline advances, stalls on a load-use
//   conflict, freezes behind a multi-cycle divide, or flushes IF/ID after a
//   taken branch. All pipeline-control outputs are Mealy: they follow the
//   current state and the same-cycle hazard inputs.
//
// Ports:
//   clk           - rising-edge clock for all state
//   rst_n         - synchronous active-low reset
//   conf_LW       - load-use conflict seen by the ID-stage forwarding unit
//   branch_taken  - ID-stage branch/jump resolved as taken
//   div_start     - EXE-stage multi-cycle divide issued this cycle
//   div_done      - divider result valid this cycle
//   pc_ena        - PC register write enable
//   ifid_ena      - IF/ID register write enable
//   ifid_flush    - clear IF/ID to NOP at the next edge
//   idexe_ena     - ID/EXE register write enable
//   idexe_bubble  - load NOP into ID/EXE at the next edge
//   exemem_bubble - load NOP into EXE/MEM at the next edge
//   stall_cycles  - saturating count of cycles with pc_ena low since reset
//   hazard_err    - sticky timeout flag (load-stall or divide)
//   state         - current state: RUN=0, LW_STALL=1, DIV_BUSY=2
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int DIV_TIMEOUT = 63,
    parameter int LW_MAX      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        conf_LW,
    input  logic        branch_taken,
    input  logic        div_start,
    input  logic        div_done,
    output logic        pc_ena,
    output logic        ifid_ena,
    output logic        ifid_flush,
    output logic        idexe_ena,
    output logic        idexe_bubble,
    output logic        exemem_bubble,
    output logic [31:0] stall_cycles,
    output logic        hazard_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LW_STALL = 2'd1,
        DIV_BUSY = 2'd2
    } HazardState;

    localparam int LW_W  = $clog2(LW_MAX + 1);
    localparam int DIV_W = $clog2(DIV_TIMEOUT + 1);

    // LW_LAST is the count value at which one more stall cycle would exceed
    // the allowed run; LW_SAT keeps the counter from wrapping on long stalls.
    localparam logic [LW_W-1:0]  LW_LAST  = LW_W'(LW_MAX - 1);
    localparam logic [LW_W-1:0]  LW_SAT   = LW_W'(LW_MAX);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_TIMEOUT - 1);

    HazardState       r_state;
    HazardState       w_nextState;
    logic [LW_W-1:0]  r_lwCnt;
    logic [DIV_W-1:0] r_divCnt;
    logic [31:0]      r_stallCycles;
    logic             r_hazardErr;

    logic             w_lwClr;
    logic             w_lwInc;
    logic             w_divClr;
    logic             w_divInc;
    logic             w_setErr;

    // Next-state and output decode. The divide unit owns the pipeline while
    // it is busy or being started; load-use comes next; a taken branch only
    // flushes when nothing else is stalling, because a stalled branch will be
    // resolved again by ID once the stall clears. Reset overrides everything
    // at the end so the pipeline sees a full flush while rst_n is low.
    always_comb begin
        w_nextState   = r_state;
        pc_ena        = 1'b1;
        ifid_ena      = 1'b1;
        ifid_flush    = 1'b0;
        idexe_ena     = 1'b1;
        idexe_bubble  = 1'b0;
        exemem_bubble = 1'b0;
        w_lwClr       = 1'b0;
        w_lwInc       = 1'b0;
        w_divClr      = 1'b0;
        w_divInc      = 1'b0;
        w_setErr      = 1'b0;

        if (r_state == DIV_BUSY) begin
            if (div_done) begin
                // Result is ready: release this cycle. A load-use conflict
                // arriving together with the release is honoured right away.
                if (conf_LW) begin
                    pc_ena       = 1'b0;
                    ifid_ena     = 1'b0;
                    idexe_bubble = 1'b1;
                    w_lwClr      = 1'b1;
                    w_nextState  = LW_STALL;
                end else begin
                    w_nextState  = RUN;
                end
            end else begin
                pc_ena        = 1'b0;
                ifid_ena      = 1'b0;
                idexe_ena     = 1'b0;
                exemem_bubble = 1'b1;
                // The last permitted busy cycle flags the error and gives
                // the pipeline back rather than hanging forever.
                if (r_divCnt == DIV_LAST) begin
                    w_setErr    = 1'b1;
                    w_nextState = RUN;
                end else begin
                    w_divInc    = 1'b1;
                end
            end
        end else if (div_start) begin
            pc_ena        = 1'b0;
            ifid_ena      = 1'b0;
            idexe_ena     = 1'b0;
            exemem_bubble = 1'b1;
            w_divClr      = 1'b1;
            w_lwClr       = 1'b1;
            w_nextState   = DIV_BUSY;
        end else if (conf_LW) begin
            pc_ena       = 1'b0;
            ifid_ena     = 1'b0;
            idexe_bubble = 1'b1;
            w_nextState  = LW_STALL;
            // Only cycles spent already stalled count towards the limit;
            // the first conflict cycle in RUN starts the run from zero.
            if (r_state == LW_STALL) begin
                w_lwInc = 1'b1;
                if (r_lwCnt >= LW_LAST) begin
                    w_setErr = 1'b1;
                end
            end else begin
                w_lwClr = 1'b1;
            end
        end else begin
            ifid_flush  = branch_taken;
            w_lwClr     = 1'b1;
            w_nextState = RUN;
        end

        if (!rst_n) begin
            pc_ena        = 1'b0;
            ifid_ena      = 1'b0;
            idexe_ena     = 1'b0;
            ifid_flush    = 1'b1;
            idexe_bubble  = 1'b1;
            exemem_bubble = 1'b1;
        end
    end

    // State register plus the two hazard counters, the sticky error flag and
    // the stall-cycle statistic. The statistic samples pc_ena after decode,
    // so it counts exactly the cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_lwCnt       <= '0;
            r_divCnt      <= '0;
            r_stallCycles <= '0;
            r_hazardErr   <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_lwClr) begin
                r_lwCnt <= '0;
            end else if (w_lwInc && (r_lwCnt != LW_SAT)) begin
                r_lwCnt <= r_lwCnt + 1'b1;
            end

            if (w_divClr) begin
                r_divCnt <= '0;
            end else if (w_divInc) begin
                r_divCnt <= r_divCnt + 1'b1;
            end

            if (w_setErr) begin
                r_hazardErr <= 1'b1;
            end

            if (!pc_ena && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign hazard_err   = r_hazardErr;
    assign state        = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Purpose:
//   Directed self-checking bench for hazard_stall_ctrl with default
//   parameters (DIV_TIMEOUT=63, LW_MAX=2). Inputs change on the falling
//   edge; outputs and state are sampled 1 ns later, away from the rising
//   edge. Each scenario task compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        conf_LW;
    logic        branch_taken;
    logic        div_start;
    logic        div_done;
    logic        pc_ena;
    logic        ifid_ena;
    logic        ifid_flush;
    logic        idexe_ena;
    logic        idexe_bubble;
    logic        exemem_bubble;
    logic [31:0] stall_cycles;
    logic        hazard_err;
    logic [1:0]  state;

    logic [5:0]  obs;
    int          passCount;
    int          checkCount;

    // Output bundle order: {pc_ena, ifid_ena, ifid_flush, idexe_ena,
    // idexe_bubble, exemem_bubble}
    localparam logic [5:0] DEF_OUT = 6'b110100;
    localparam logic [5:0] LW_OUT  = 6'b000110;
    localparam logic [5:0] FRZ_OUT = 6'b000001;
    localparam logic [5:0] BR_OUT  = 6'b111100;
    localparam logic [5:0] RST_OUT = 6'b001011;

    hazard_stall_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .conf_LW       (conf_LW),
        .branch_taken  (branch_taken),
        .div_start     (div_start),
        .div_done      (div_done),
        .pc_ena        (pc_ena),
        .ifid_ena      (ifid_ena),
        .ifid_flush    (ifid_flush),
        .idexe_ena     (idexe_ena),
        .idexe_bubble  (idexe_bubble),
        .exemem_bubble (exemem_bubble),
        .stall_cycles  (stall_cycles),
        .hazard_err    (hazard_err),
        .state         (state)
    );

    assign obs = {pc_ena, ifid_ena, ifid_flush, idexe_ena, idexe_bubble, exemem_bubble};

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives the four hazard inputs together.
    task automatic applyStimulus(input logic c, input logic b, input logic s, input logic d);
        conf_LW      = c;
        branch_taken = b;
        div_start    = s;
        div_done     = d;
    endtask

    // One cycle: drive on the falling edge, leave 1 ns to settle.
    task automatic step(input logic c, input logic b, input logic s, input logic d);
        @(negedge clk);
        applyStimulus(c, b, s, d);
        #1;
    endtask

    // One cycle of reset with idle inputs, then release.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkCount++;
        if (obs !== RST_OUT) $display("[TB] FAIL reset_outputs: got %b expected %b", obs, RST_OUT);
        else passCount++;
        checkCount++;
        if ({state, hazard_err} !== 3'b000) $display("[TB] FAIL reset_state_err: got %b expected %b", {state, hazard_err}, 3'b000);
        else passCount++;
        checkCount++;
        if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_stall_cycles: got %0d expected %0d", stall_cycles, 0);
        else passCount++;

        // Hazard inputs must not leak through while reset is held.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checkCount++;
        if (obs !== RST_OUT) $display("[TB] FAIL reset_overrides_hazards: got %b expected %b", obs, RST_OUT);
        else passCount++;

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkCount++;
        if ({state, obs} !== {2'd0, DEF_OUT}) $display("[TB] FAIL reset_release_default: got %b expected %b", {state, obs}, {2'd0, DEF_OUT});
        else passCount++;
    endtask

    task automatic test_load_use();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, LW_OUT}) $display("[TB] FAIL lu_first_cycle: got %b expected %b", {state, obs}, {2'd0, LW_OUT});
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd1, DEF_OUT}) $display("[TB] FAIL lu_release: got %b expected %b", {state, obs}, {2'd1, DEF_OUT});
        else passCount++;
        checkCount++;
        if (stall_cycles !== 32'd1) $display("[TB] FAIL lu_stall_cycles: got %0d expected %0d", stall_cycles, 1);
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, DEF_OUT}) $display("[TB] FAIL lu_back_in_run: got %b expected %b", {state, obs}, {2'd0, DEF_OUT});
        else passCount++;
    endtask

    task automatic test_branch_under_stall();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checkCount++;
        if (obs !== LW_OUT) $display("[TB] FAIL br_suppressed_by_lw: got %b expected %b", obs, LW_OUT);
        else passCount++;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd1, BR_OUT}) $display("[TB] FAIL br_after_stall: got %b expected %b", {state, obs}, {2'd1, BR_OUT});
        else passCount++;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, BR_OUT}) $display("[TB] FAIL br_in_run: got %b expected %b", {state, obs}, {2'd0, BR_OUT});
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({stall_cycles, hazard_err} !== {32'd2, 1'b0}) $display("[TB] FAIL br_stall_count_err: got %0d/%b expected %0d/%b", stall_cycles, hazard_err, 2, 1'b0);
        else passCount++;
    endtask

    task automatic test_divide();
        doReset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, FRZ_OUT}) $display("[TB] FAIL div_start_freeze: got %b expected %b", {state, obs}, {2'd0, FRZ_OUT});
        else passCount++;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checkCount++;
            if ({state, obs} !== {2'd2, FRZ_OUT}) $display("[TB] FAIL div_busy_cycle_%0d: got %b expected %b", k, {state, obs}, {2'd2, FRZ_OUT});
            else passCount++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checkCount++;
        if ({state, obs} !== {2'd2, DEF_OUT}) $display("[TB] FAIL div_done_release: got %b expected %b", {state, obs}, {2'd2, DEF_OUT});
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, hazard_err} !== 3'b000) $display("[TB] FAIL div_after_state_err: got %b expected %b", {state, hazard_err}, 3'b000);
        else passCount++;
        checkCount++;
        if (stall_cycles !== 32'd11) $display("[TB] FAIL div_stall_cycles: got %0d expected %0d", stall_cycles, 11);
        else passCount++;
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, FRZ_OUT}) $display("[TB] FAIL sim_div_over_lw: got %b expected %b", {state, obs}, {2'd0, FRZ_OUT});
        else passCount++;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd2, FRZ_OUT}) $display("[TB] FAIL sim_br_in_div_busy: got %b expected %b", {state, obs}, {2'd2, FRZ_OUT});
        else passCount++;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checkCount++;
        if ({state, obs} !== {2'd2, LW_OUT}) $display("[TB] FAIL sim_done_with_lw: got %b expected %b", {state, obs}, {2'd2, LW_OUT});
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd1, DEF_OUT}) $display("[TB] FAIL sim_lw_stall_entered: got %b expected %b", {state, obs}, {2'd1, DEF_OUT});
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, hazard_err} !== 3'b000) $display("[TB] FAIL sim_back_in_run: got %b expected %b", {state, hazard_err}, 3'b000);
        else passCount++;
    endtask

    task automatic test_lw_timeout();
        doReset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, LW_OUT}) $display("[TB] FAIL lwto_cycle1: got %b expected %b", {state, obs}, {2'd0, LW_OUT});
        else passCount++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs, hazard_err} !== {2'd1, LW_OUT, 1'b0}) $display("[TB] FAIL lwto_cycle2: got %b expected %b", {state, obs, hazard_err}, {2'd1, LW_OUT, 1'b0});
        else passCount++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd1, LW_OUT}) $display("[TB] FAIL lwto_cycle3: got %b expected %b", {state, obs}, {2'd1, LW_OUT});
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs, hazard_err} !== {2'd1, DEF_OUT, 1'b1}) $display("[TB] FAIL lwto_err_set: got %b expected %b", {state, obs, hazard_err}, {2'd1, DEF_OUT, 1'b1});
        else passCount++;
        checkCount++;
        if (stall_cycles !== 32'd3) $display("[TB] FAIL lwto_stall_cycles: got %0d expected %0d", stall_cycles, 3);
        else passCount++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, hazard_err} !== 3'b001) $display("[TB] FAIL lwto_err_sticky: got %b expected %b", {state, hazard_err}, 3'b001);
        else passCount++;
    endtask

    task automatic test_div_timeout();
        doReset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd0, FRZ_OUT}) $display("[TB] FAIL divto_start: got %b expected %b", {state, obs}, {2'd0, FRZ_OUT});
        else passCount++;
        for (int k = 1; k <= 63; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checkCount++;
            if ({state, obs, hazard_err} !== {2'd2, FRZ_OUT, 1'b0}) $display("[TB] FAIL divto_busy_%0d: got %b expected %b", k, {state, obs, hazard_err}, {2'd2, FRZ_OUT, 1'b0});
            else passCount++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs, hazard_err} !== {2'd0, DEF_OUT, 1'b1}) $display("[TB] FAIL divto_forced_run: got %b expected %b", {state, obs, hazard_err}, {2'd0, DEF_OUT, 1'b1});
        else passCount++;
        checkCount++;
        if (stall_cycles !== 32'd64) $display("[TB] FAIL divto_stall_cycles: got %0d expected %0d", stall_cycles, 64);
        else passCount++;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        checkCount++;
        if (hazard_err !== 1'b1) $display("[TB] FAIL divto_err_sticky: got %b expected %b", hazard_err, 1'b1);
        else passCount++;
        doReset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, hazard_err} !== 3'b000) $display("[TB] FAIL divto_err_cleared: got %b expected %b", {state, hazard_err}, 3'b000);
        else passCount++;
    endtask

    task automatic test_mid_div_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        checkCount++;
        if ({state, obs} !== {2'd2, FRZ_OUT}) $display("[TB] FAIL mdr_in_div_busy: got %b expected %b", {state, obs}, {2'd2, FRZ_OUT});
        else passCount++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (obs !== RST_OUT) $display("[TB] FAIL mdr_reset_outputs: got %b expected %b", obs, RST_OUT);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkCount++;
        if ({state, obs} !== {2'd0, DEF_OUT}) $display("[TB] FAIL mdr_after_release: got %b expected %b", {state, obs}, {2'd0, DEF_OUT});
        else passCount++;
        checkCount++;
        if (stall_cycles !== 32'd0) $display("[TB] FAIL mdr_stall_cycles: got %0d expected %0d", stall_cycles, 0);
        else passCount++;
    endtask

    // Scenarios run back to back; each one starts from RUN and either
    // resets first or relies on the stall count left by the one before.
    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_load_use();
        test_branch_under_stall();
        test_divide();
        test_simultaneous();
        test_lw_timeout();
        test_div_timeout();
        test_mid_div_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter DIV_TIMEOUT, default 63: maximum cycles the controller waits in DIV_BUSY before flagging an error.
REQ-002 Parameter LW_MAX, default 2: maximum consecutive load-use stall cycles before flagging an error.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port conf_LW, input, 1: combinational load-use conflict from the ID-stage forwarding unit.
REQ-007 Port branch_taken, input, 1: ID-stage branch/jump resolved as taken.
REQ-008 Port div_start, input, 1: EXE-stage multi-cycle divide issued this cycle.
REQ-009 Port div_done, input, 1: divider result valid this cycle.
REQ-010 Port pc_ena, output, 1: PC register write enable.
REQ-011 Port ifid_ena, output, 1: IF/ID register write enable.
REQ-012 Port ifid_flush, output, 1: clear IF/ID to NOP at the next edge.
REQ-013 Port idexe_ena, output, 1: ID/EXE register write enable.
REQ-014 Port idexe_bubble, output, 1: load NOP into ID/EXE at the next edge.
REQ-015 Port exemem_bubble, output, 1: load NOP into EXE/MEM at the next edge.
REQ-016 Port stall_cycles, output, 32: count of cycles with pc_ena=0 since reset, saturating.
REQ-017 Port hazard_err, output, 1: sticky timeout error flag.
REQ-018 Port state, output, 2: current state encoding; RUN=0, LW_STALL=1, DIV_BUSY=2.

Function
REQ-019 States: RUN, LW_STALL, DIV_BUSY. Outputs are Mealy, driven combinationally from the state and same-cycle inputs.
REQ-020 Priority: DIV_BUSY or div_start first, then conf_LW, then branch_taken.
REQ-021 Default outputs (no hazard, RUN): pc_ena=1, ifid_ena=1, idexe_ena=1, all flush and bubble outputs 0.
REQ-022 Load-use response when conf_LW=1 and no divide is active:
  - pc_ena=0, ifid_ena=0, idexe_bubble=1, idexe_ena=1, all in the same cycle.
  - Next state is LW_STALL.
REQ-023 Load-stall counter:
  - LW_STALL holds while conf_LW=1 and increments a load counter each cycle.
  - When conf_LW=0, the controller returns to RUN and clears the counter.
REQ-024 If the load counter reaches LW_MAX while conf_LW is still 1, hazard_err is set; stalling continues.
REQ-025 Divide start: div_start=1 in RUN or LW_STALL freezes the pipeline in the same cycle:
  - pc_ena=0, ifid_ena=0, idexe_ena=0, exemem_bubble=1.
  - Next state is DIV_BUSY and the divide counter is cleared.
REQ-026 DIV_BUSY behaviour:
  - While div_done=0: hold the freeze outputs and increment the divide counter.
  - When div_done=1: release that same cycle with the default outputs and go to RUN.
REQ-027 If the divide counter reaches DIV_TIMEOUT in DIV_BUSY, set hazard_err and force a return to RUN.
REQ-028 Taken branch with no stall: branch_taken=1 in RUN with conf_LW=0 and div_start=0 gives ifid_flush=1, pc_ena=1, ifid_ena=1.
REQ-029 Branch suppression: branch_taken is ignored (ifid_flush=0) in any cycle where conf_LW=1, div_start=1, or the state is DIV_BUSY.
  - ID re-resolves the branch after the stall clears.
REQ-030 Simultaneous div_start and conf_LW: the divide freeze applies and idexe_bubble=0.
REQ-031 Simultaneous div_done and conf_LW in DIV_BUSY: the load-use response of REQ-022 applies and the next state is LW_STALL.
REQ-032 stall_cycles increments at each edge where pc_ena=0 and rst_n=1, and saturates at 32'hFFFFFFFF.
REQ-033 hazard_err clears only on reset.

Reset
REQ-034 When rst_n=0 at a rising edge:
  - State becomes RUN.
  - The load counter, divide counter and stall_cycles become 0.
  - hazard_err becomes 0.
REQ-035 While rst_n=0, outputs are: pc_ena=0, ifid_ena=0, idexe_ena=0, ifid_flush=1, idexe_bubble=1, exemem_bubble=1.
REQ-036 Reset asserted in LW_STALL or DIV_BUSY aborts the operation; the first cycle after release is RUN with default outputs.

Verification
REQ-037 Load-use: conf_LW=1 for 1 cycle.
  - That cycle: pc_ena=0, idexe_bubble=1, state becomes 1.
  - Next cycle: conf_LW=0 gives pc_ena=1 and state 0; stall_cycles=1.
REQ-038 Divide: div_start pulse, then div_done asserted 10 cycles later.
  - Freeze lasts 11 cycles total.
  - Release happens in the div_done cycle; stall_cycles=11; hazard_err=0.
REQ-039 Divide timeout: div_start with div_done held 0.
  - After 63 DIV_BUSY cycles: hazard_err=1 and state returns to 0.
  - hazard_err stays 1 until rst_n=0.
REQ-040 Branch under stall: branch_taken=1 with conf_LW=1 gives ifid_flush=0.
  - Next cycle with conf_LW=0 and branch_taken=1 gives ifid_flush=1.
REQ-041 Mid-divide reset: rst_n=0 for 1 cycle in DIV_BUSY.
  - State becomes 0, stall_cycles=0, pc_ena=1 after release.
REQ-042 Load-use timeout: conf_LW held 1 for 3 cycles.
  - hazard_err=1 once the counter reaches 2.
  - pc_ena stays 0 throughout.
